// File: rtl/nn_mul_arbiter.sv
// Round-robin arbiter feeding a two-stage operand/product pipeline that shares
// one unsigned A_WIDTH x B_WIDTH multiplier between NUM_REQ requesters.
module nn_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int A_WIDTH  = 39,
  parameter int B_WIDTH  = 4,
  parameter int P_WIDTH  = 43
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic [P_WIDTH-1:0]           res_data,
  output logic                         busy
);

  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                s1_v_q, s1_v_d;
  logic [ID_WIDTH-1:0] s1_id_q, s1_id_d;
  logic [A_WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [B_WIDTH-1:0]  s1_b_q, s1_b_d;
  logic                res_valid_q, res_valid_d;
  logic [ID_WIDTH-1:0] res_id_q, res_id_d;
  logic [P_WIDTH-1:0]  res_data_q, res_data_d;

  logic                s1_en, s2_en;
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] cand;
  logic [P_WIDTH-1:0]  product;

  assign s2_en   = !res_valid_q || res_ready;
  assign s1_en   = !s1_v_q || s2_en;
  assign product = P_WIDTH'(s1_a_q) * P_WIDTH'(s1_b_q);

  // Scan from rr_ptr upward; the index arithmetic wraps because NUM_REQ is 2**ID_WIDTH.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr_q + ID_WIDTH'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (ap_rst_n && s1_en && grant_found) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    s1_v_d      = s1_v_q;
    s1_id_d     = s1_id_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    if (s1_en) begin
      s1_v_d = grant_found;
      if (grant_found) begin
        s1_id_d  = grant_id;
        s1_a_d   = req_a[grant_id*A_WIDTH +: A_WIDTH];
        s1_b_d   = req_b[grant_id*B_WIDTH +: B_WIDTH];
        rr_ptr_d = grant_id + ID_WIDTH'(1);
      end
    end
    if (s2_en) begin
      res_valid_d = s1_v_q;
      if (s1_v_q) begin
        res_id_d   = s1_id_q;
        res_data_d = product;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr_q    <= '0;
      s1_v_q      <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_v_q      <= s1_v_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign busy      = s1_v_q || res_valid_q;

endmodule

// File: tb/tb_nn_mul_arbiter.sv
// Scenario bench for nn_mul_arbiter: expected products are queued when a grant is
// predicted and compared in order when the result stream hands them off.
module tb_nn_mul_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 39;
  localparam int BW = 4;
  localparam int PW = 43;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            res_valid;
  logic            res_ready;
  logic [IW-1:0]   res_id;
  logic [PW-1:0]   res_data;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] data;
  } exp_t;
  exp_t sb[$];

  nn_mul_arbiter #(
    .NUM_REQ(N), .ID_WIDTH(IW), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  function automatic logic [PW-1:0] model_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [PW-1:0] acc = '0;
    for (int k = 0; k < BW; k++)
      if (b[k]) acc = acc + ({{(PW-AW){1'b0}}, a} << k);
    return acc;
  endfunction

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0; req_valid = '0; res_ready = 1'b1;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    @(negedge ap_clk);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (res_id !== '0) begin n_fail++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
    n_checks++; if (res_data !== '0) begin n_fail++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
    req_valid = '1;
    #1;
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    @(negedge ap_clk);
    req_valid = '0; ap_rst_n = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      @(posedge ap_clk); #1;
      if (c == 0) begin set_op(2, 39'd1000, 4'd7); req_valid = 4'b0100; res_ready = 1'b1; end
      if (c == 1) req_valid = '0;
      @(negedge ap_clk);
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL single_unexpected: got id=%0d data=%0d want none", res_id, res_data); end
        else begin
          e = sb.pop_front();
          if ({res_id, res_data} !== {e.id, e.data}) begin n_fail++;
            $display("FAIL single_result: got id=%0d data=%0d want id=%0d data=%0d", res_id, res_data, e.id, e.data); end
        end
      end
      case (c)
        0: begin
          n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", req_ready); end
          sb.push_back('{id: 2'd2, data: 43'd7000});
        end
        1: begin
          n_checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL single_s1_only: got res_valid=%b busy=%b want 0 1", res_valid, busy); end
        end
        2: begin
          n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got res_valid=%b want 1", res_valid); end
        end
        default: begin
          n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++;
            $display("FAIL single_idle: got busy=%b res_valid=%b want 0 0", busy, res_valid); end
        end
      endcase
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_contention();
    exp_t e;
    logic [AW-1:0] a [N];
    int g = 0;
    do_reset();
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(64'd1000003 * (i + 1) + 64'h55_0000_0000);
      set_op(i, a[i], BW'(i + 1));
    end
    for (int c = 0; c < 16; c++) begin
      @(posedge ap_clk); #1;
      if (c == 0) begin req_valid = 4'hF; res_ready = 1'b1; end
      if (c == 12) req_valid = '0;
      @(negedge ap_clk);
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL contention_unexpected: got id=%0d data=%0d want none", res_id, res_data); end
        else begin
          e = sb.pop_front();
          if ({res_id, res_data} !== {e.id, e.data}) begin n_fail++;
            $display("FAIL contention_result: got id=%0d data=%0d want id=%0d data=%0d", res_id, res_data, e.id, e.data); end
        end
      end
      if (c < 12) begin
        n_checks++; if (req_ready !== N'(1 << g)) begin n_fail++;
          $display("FAIL contention_grant: cycle %0d got %b want %b", c, req_ready, N'(1 << g)); end
        sb.push_back('{id: IW'(g), data: model_mul(a[g], BW'(g + 1))});
        g = (g + 1) % N;
      end
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL contention_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_max();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      @(posedge ap_clk); #1;
      if (c == 0) begin set_op(1, 39'h7F_FFFF_FFFF, 4'hF); req_valid = 4'b0010; end
      if (c == 1) req_valid = '0;
      @(negedge ap_clk);
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL max_unexpected: got id=%0d data=%0d want none", res_id, res_data); end
        else begin
          e = sb.pop_front();
          if ({res_id, res_data} !== {e.id, e.data}) begin n_fail++;
            $display("FAIL max_result: got id=%0d data=%h want id=%0d data=%h", res_id, res_data, e.id, e.data); end
        end
      end
      if (c == 0) begin
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL max_grant: got %b want 0010", req_ready); end
        sb.push_back('{id: 2'd1, data: 43'h77F_FFFF_FFF1});
      end
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL max_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    for (int c = 0; c < 11; c++) begin
      @(posedge ap_clk); #1;
      case (c)
        0: begin res_ready = 1'b0; set_op(2, 39'd123456789, 4'd9); set_op(0, 39'd555, 4'd3); req_valid = 4'b0101; end
        1: set_op(2, 39'h40_0000_0005, 4'd2);
        2: req_valid = 4'b0100;
        7: res_ready = 1'b1;
        8: req_valid = '0;
        default: ;
      endcase
      @(negedge ap_clk);
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL bp_unexpected: got id=%0d data=%0d want none", res_id, res_data); end
        else begin
          e = sb.pop_front();
          if ({res_id, res_data} !== {e.id, e.data}) begin n_fail++;
            $display("FAIL bp_result: got id=%0d data=%0d want id=%0d data=%0d", res_id, res_data, e.id, e.data); end
        end
      end
      if (c == 0) begin
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant0: got %b want 0100", req_ready); end
        sb.push_back('{id: 2'd2, data: 43'd1111111101});
      end else if (c == 1) begin
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant1: got %b want 0001", req_ready); end
        sb.push_back('{id: 2'd0, data: 43'd1665});
      end else if (c <= 6) begin
        n_checks++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 43'd1111111101) begin n_fail++;
          $display("FAIL bp_stall_hold: cycle %0d got v=%b id=%0d data=%0d want 1 2 1111111101", c, res_valid, res_id, res_data); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready: cycle %0d got %b want 0000", c, req_ready); end
      end else if (c == 7) begin
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_grant: got %b want 0100", req_ready); end
        sb.push_back('{id: 2'd2, data: 43'h080_0000_000A});
      end
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_wrap();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      @(posedge ap_clk); #1;
      if (c == 0) begin set_op(0, 39'd10, 4'd1); set_op(3, 39'd20, 4'd2); req_valid = 4'b1001; res_ready = 1'b1; end
      if (c == 2) req_valid = '0;
      @(negedge ap_clk);
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL wrap_unexpected: got id=%0d data=%0d want none", res_id, res_data); end
        else begin
          e = sb.pop_front();
          if ({res_id, res_data} !== {e.id, e.data}) begin n_fail++;
            $display("FAIL wrap_result: got id=%0d data=%0d want id=%0d data=%0d", res_id, res_data, e.id, e.data); end
        end
      end
      if (c == 0) begin
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b want 1000", req_ready); end
        sb.push_back('{id: 2'd3, data: 43'd40});
      end else if (c == 1) begin
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_second: got %b want 0001", req_ready); end
        sb.push_back('{id: 2'd0, data: 43'd10});
      end
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    @(posedge ap_clk); #1;
    res_ready = 1'b0; set_op(1, 39'd77, 4'd5); req_valid = 4'b0010;
    @(negedge ap_clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_fill1: got %b want 0010", req_ready); end
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_fill2: got %b want 0010", req_ready); end
    @(posedge ap_clk); #1;
    req_valid = 4'b0110; set_op(1, 39'd11, 4'd3); set_op(2, 39'd6, 4'd6);
    @(negedge ap_clk);
    n_checks++; if (res_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL rmid_full: got v=%b busy=%b ready=%b want 1 1 0000", res_valid, busy, req_ready); end
    ap_rst_n = 1'b0;
    #1;
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL rmid_async: got v=%b busy=%b ready=%b want 0 0 0000", res_valid, busy, req_ready); end
    sb.delete();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1; res_ready = 1'b1;
    @(negedge ap_clk);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got res_valid=%b want 0", res_valid); end
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_first_grant: got %b want 0010", req_ready); end
    sb.push_back('{id: 2'd1, data: 43'd33});
    @(posedge ap_clk); #1;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rmid_unexpected: got id=%0d data=%0d want none", res_id, res_data); end
        else begin
          e = sb.pop_front();
          if ({res_id, res_data} !== {e.id, e.data}) begin n_fail++;
            $display("FAIL rmid_result: got id=%0d data=%0d want id=%0d data=%0d", res_id, res_data, e.id, e.data); end
        end
      end
      @(posedge ap_clk); #1;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rmid_drain: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_max();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_mul_arbiter.md
# nn_mul_arbiter

Round-robin arbiter and two-stage pipeline that shares a single 39x4 unsigned multiplier between NUM_REQ requesters in the NN datapath. Each requester offers operands on a valid/ready channel. The block grants one requester per cycle and registers the operands. It multiplies them through the shared combinational multiplier and returns a tagged 43-bit product on one output stream with backpressure.

## Interface
- NUM_REQ, 4: number of requesters; power of two, 2..16
- ID_WIDTH, 2: log2(NUM_REQ)
- A_WIDTH, 39: operand A width, unsigned
- B_WIDTH, 4: operand B width, unsigned
- P_WIDTH, 43: product width; must equal A_WIDTH+B_WIDTH
- ap_clk  in  1  clock, rising edge; one clock domain
- ap_rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*A_WIDTH  operand A; requester i uses bits [i*A_WIDTH +: A_WIDTH]
- req_b  in  NUM_REQ*B_WIDTH  operand B; requester i uses bits [i*B_WIDTH +: B_WIDTH]
- res_valid  out  1  product valid
- res_ready  in  1  downstream accept
- res_id  out  ID_WIDTH  index of the requester that owns res_data
- res_data  out  P_WIDTH  unsigned product A*B
- busy  out  1  high while any operation is in flight (s1_v | res_valid)

## Operation
- Stage S1 holds the operand register: s1_v, s1_id, s1_a, s1_b.
- Stage S2 holds the output register: res_valid, res_id, res_data.
- s2_en = !res_valid | res_ready. s1_en = !s1_v | s2_en. This is standard pipeline backpressure with no bubbles.
- Arbitration:
  - Combinational search starts at rr_ptr and scans upward with wrap to NUM_REQ-1 then 0.
  - The first i with req_valid[i] is granted.
  - req_ready[i] = s1_en & grant[i]. At most one bit is ever set.
- A handshake on requester g (req_valid[g] & req_ready[g]) causes:
  - s1_v<=1, s1_id<=g, s1_a/s1_b<=slice g.
  - rr_ptr<=(g+1) mod NUM_REQ.
- If s1_en is high and there is no grant, s1_v<=0.
- If s1_en is low, S1 holds all fields and rr_ptr holds.
- When s2_en is high:
  - res_valid<=s1_v.
  - If s1_v, res_id<=s1_id and res_data<=zero-extend(s1_a)*zero-extend(s1_b), full P_WIDTH, no truncation or rounding.
- When s2_en is low, S2 holds all fields.
- res_data and res_id are valid only while res_valid is high. They keep their last value otherwise.
- req_ready depends on req_valid, so requesters must not gate req_valid on req_ready.
- A requester that drops req_valid before a handshake is simply skipped. No grant state is retained.
- Reset (asynchronous, any time):
  - s1_v=0, res_valid=0, res_id=0, res_data=0, rr_ptr=0, busy=0.
  - req_ready is forced to 0 while ap_rst_n is low.
  - In-flight operations are discarded with no output.

## Timing
- Latency: a handshake at rising edge N presents res_valid=1 with the product after edge N+1, so it is visible in cycle N+1 to N+2. Total is 2 edges to capture into S2 when there is no stall.
- Throughput: one product per cycle while res_ready is held high.
- Stall: with res_valid=1 and res_ready=0, S2 holds. S1 can still fill if it is empty, then req_ready goes to all zero.
- Release edge: raising res_ready advances S2 and S1 at the same edge, and a new grant is possible at that same edge.
- Simultaneous requests: strict rotation. No requester waits more than NUM_REQ-1 grants while asserting valid.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Test plan
- Single request: after reset, requester 2 offers a=1000, b=7, res_ready=1. Required: req_ready=4'b0100 for one cycle, then res_valid=1, res_id=2, res_data=7000 two edges after the handshake, and busy=0 afterwards.
- Contention: all four valid continuously with b=i+1, res_ready=1. Required grant order is 0,1,2,3,0,... with one per cycle, and res_id follows the same sequence.
- Maximum operands: a=0x7F_FFFF_FFFF, b=0xF. Required: res_data=0x77F_FFFF_FFF1 (8246337208305).
- Backpressure: res_ready=0 for 5 cycles with 2 operations queued. Required: res_valid, res_id and res_data stay stable, req_ready=0 after S1 fills, and no operation is lost or duplicated after release.
- Wrap-around: rr_ptr=3 with requesters 0 and 3 valid. Required: 3 is granted first, then 0.
- Reset mid-operation: assert ap_rst_n=0 with S1 and S2 full. Required: res_valid=0, busy=0 and req_ready=0 immediately, no stale result after reset release, and the first grant goes to the lowest-index valid requester.
